// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit:
// funct7/funct3 encodings, the controller state type and signedness helpers.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

  function automatic logic aIsSigned(logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic bIsSigned(logic [2:0] f3);
    return aIsSigned(f3) && (f3 != F3_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start_i;
  logic            kill_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (output start_i, kill_i, funct3_i, op_a_i, op_b_i,
                  input  busy_o, done_o, result_o);

  modport slave  (input  start_i, kill_i, funct3_i, op_a_i, op_b_i,
                  output busy_o, done_o, result_o);

endinterface

// File: rtl/muldiv_special.sv
// Combinational detection of divide-by-zero and signed overflow; these
// results are known immediately, so the iterative datapath is bypassed.
module muldiv_special
  import muldiv_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            bypass_o,
  output logic [XLEN-1:0] result_o
);

  logic isDiv, isRem, isUnsigned, divByZero, overflow;

  assign isDiv      = funct3_i[2];
  assign isRem      = funct3_i[1];
  assign isUnsigned = funct3_i[0];
  assign divByZero  = (op_b_i == '0);
  assign overflow   = !isUnsigned && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);

  always_comb begin
    bypass_o = 1'b0;
    result_o = '0;
    if (isDiv && divByZero) begin
      bypass_o = 1'b1;
      result_o = isRem ? op_a_i : 32'hFFFF_FFFF;
    end else if (isDiv && overflow) begin
      bypass_o = 1'b1;
      result_o = isRem ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, 32 iterations plus one sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic     clk_i,
  input logic     rst_i,
  muldiv_if.slave bus
);

  muldiv_state_t   state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] magA_q, magA_d, magB_q, magB_d;
  logic            signA_q, signA_d, signB_q, signB_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            specBypass;
  logic [XLEN-1:0] specResult;
  logic            accept, newSignA, newSignB;
  logic [XLEN-1:0] newMagA, newMagB;
  logic [32:0]     mulSum, remShift;
  logic [63:0]     product;
  logic [XLEN-1:0] quotient, remainder, fixResult;

  muldiv_special uSpecial (
    .funct3_i (bus.funct3_i),
    .op_a_i   (bus.op_a_i),
    .op_b_i   (bus.op_b_i),
    .bypass_o (specBypass),
    .result_o (specResult)
  );

  assign accept   = bus.start_i && !bus.kill_i && (state_q == IDLE || state_q == DONE);
  assign newSignA = aIsSigned(bus.funct3_i) && bus.op_a_i[XLEN-1];
  assign newSignB = bIsSigned(bus.funct3_i) && bus.op_b_i[XLEN-1];
  assign newMagA  = newSignA ? -bus.op_a_i : bus.op_a_i;
  assign newMagB  = newSignB ? -bus.op_b_i : bus.op_b_i;

  // Multiply keeps the multiplier in acc low half and shifts right; divide
  // shifts dividend bits out of acc low half into the partial remainder.
  always_comb begin
    mulSum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, magA_q} : 33'd0);
    remShift  = {rem_q, acc_q[31]};
    product   = (signA_q ^ signB_q) ? -acc_q : acc_q;
    quotient  = (signA_q ^ signB_q) ? -acc_q[31:0] : acc_q[31:0];
    remainder = signA_q ? -rem_q : rem_q;
    case (f3_q)
      F3_MUL:                     fixResult = product[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixResult = product[63:32];
      F3_DIV, F3_DIVU:            fixResult = quotient;
      default:                    fixResult = remainder;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    magA_d   = magA_q;
    magB_d   = magB_q;
    signA_d  = signA_q;
    signB_d  = signB_q;
    f3_d     = f3_q;
    result_d = result_q;
    if (bus.kill_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) state_d = IDLE;
          if (accept) begin
            f3_d    = bus.funct3_i;
            signA_d = newSignA;
            signB_d = newSignB;
            magA_d  = newMagA;
            magB_d  = newMagB;
            cnt_d   = '0;
            rem_d   = '0;
            acc_d   = {32'd0, bus.funct3_i[2] ? newMagA : newMagB};
            if (specBypass) begin
              state_d  = DONE;
              result_d = specResult;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIX;
          if (f3_q[2]) begin
            if (remShift >= {1'b0, magB_q}) begin
              rem_d = remShift[31:0] - magB_q;
              acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
            end else begin
              rem_d = remShift[31:0];
              acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
            end
          end else begin
            acc_d = {mulSum, acc_q[31:1]};
          end
        end
        FIX: begin
          result_d = fixResult;
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      magA_q   <= '0;
      magB_q   <= '0;
      signA_q  <= 1'b0;
      signB_q  <= 1'b0;
      f3_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      magA_q   <= magA_d;
      magB_q   <= magB_d;
      signA_q  <= signA_d;
      signB_q  <= signB_d;
      f3_q     <= f3_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = (state_q == CALC) || (state_q == FIX);
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an arithmetic reference model predicts
// done/busy/result every cycle; directed vectors carry hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if bus();

  muldiv_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          cyc = 0;
  bit          running = 1'b0;
  bit          pendValid = 1'b0;
  bit          pendSpecial = 1'b0;
  bit          pendHasLit = 1'b0;
  int          pendAcc = 0;
  int          pendCyc = 0;
  logic [31:0] pendRes = '0;
  logic [31:0] pendLit = '0;
  logic [31:0] heldRes = '0;
  string       pendName = "";
  bit          nextHasLit = 1'b0;
  logic [31:0] nextLit = '0;
  string       nextName = "";
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] model(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          p;
    longint unsigned up;
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      F3_MULHU:  begin up = ua * ub; return up[63:32]; end
      F3_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      F3_DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub;
        return up[31:0];
      end
      F3_REM:    begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default:   begin
        if (b == 0) return a;
        up = ua % ub;
        return up[31:0];
      end
    endcase
  endfunction

  function automatic bit isSpecial(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    return f3[2] && ((b == 0) ||
           ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic bit modelBusy(int c);
    return pendValid && !pendSpecial && (c >= pendAcc) && (c < pendCyc);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every negedge, outputs must match what the model predicts.
  always @(negedge clk) begin
    if (running) begin
      logic        expDone, expBusy;
      logic [31:0] expRes;
      expDone = pendValid && (cyc == pendCyc);
      expBusy = modelBusy(cyc);
      expRes  = (pendValid && cyc >= pendCyc) ? pendRes : heldRes;
      checkOutput("done_o", 32'(bus.done_o), 32'(expDone));
      checkOutput("busy_o", 32'(bus.busy_o), 32'(expBusy));
      checkOutput("result_o", bus.result_o, expRes);
      if (expDone && pendHasLit)
        checkOutput({pendName, " literal"}, bus.result_o, pendLit);
    end
  end

  task automatic modelEdge();
    int prev = cyc - 1;
    if (rst) return;
    if (bus.kill_i) begin
      if (pendValid && pendCyc <= prev) heldRes = pendRes;
      pendValid = 1'b0;
    end else if (bus.start_i && !modelBusy(prev)) begin
      if (pendValid && pendCyc <= prev) heldRes = pendRes;
      pendValid   = 1'b1;
      pendAcc     = cyc;
      pendSpecial = isSpecial(bus.funct3_i, bus.op_a_i, bus.op_b_i);
      pendCyc     = cyc + (pendSpecial ? 0 : 33);
      pendRes     = model(bus.funct3_i, bus.op_a_i, bus.op_b_i);
      pendHasLit  = nextHasLit;
      pendLit     = nextLit;
      pendName    = nextName;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    modelEdge();
  endtask

  task automatic applyStimulus(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                               bit hasLit, logic [31:0] lit, string name, bit kill);
    bus.start_i  = 1'b1;
    bus.kill_i   = kill;
    bus.funct3_i = f3;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    nextHasLit   = hasLit;
    nextLit      = lit;
    nextName     = name;
    tick();
    bus.start_i  = 1'b0;
    bus.kill_i   = 1'b0;
    bus.funct3_i = 3'($urandom_range(0, 7));
    bus.op_a_i   = $urandom;
    bus.op_b_i   = $urandom;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 40 && !(pendValid && cyc >= pendCyc); i++) tick();
  endtask

  task automatic pulseReset();
    #1 rst = 1'b1;
    pendValid = 1'b0;
    heldRes   = '0;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.kill_i   = 1'b0;
    bus.funct3_i = '0;
    bus.op_a_i   = '0;
    bus.op_b_i   = '0;
    running      = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    tick();

    applyStimulus(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, "MUL 7*-3", 0);
    waitDone();
    tick(); tick();

    applyStimulus(F3_MULH, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, "MULH min*min", 0);
    waitDone();
    applyStimulus(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, "MULHU max*max", 0);
    waitDone();
    applyStimulus(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, "MULHSU -1*max", 0);
    waitDone();
    applyStimulus(F3_MULH, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF, "MULH -1*2", 0);
    waitDone();
    applyStimulus(F3_MUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 32'd6, "MUL -2*-3", 0);
    waitDone();
    tick();

    // Divides issued back-to-back in each DONE cycle.
    applyStimulus(F3_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, "DIV -7/2", 0);
    waitDone();
    applyStimulus(F3_REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, "REM -7/2", 0);
    waitDone();
    applyStimulus(F3_DIVU, 32'd100, 32'd7, 1, 32'd14, "DIVU 100/7", 0);
    waitDone();
    applyStimulus(F3_REMU, 32'd100, 32'd7, 1, 32'd2, "REMU 100/7", 0);
    waitDone();
    applyStimulus(F3_DIV, 32'd7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, "DIV 7/-2", 0);
    waitDone();
    applyStimulus(F3_REM, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, "REM 7/-2", 0);
    waitDone();
    tick(); tick();

    applyStimulus(F3_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "DIV 5/0", 0);
    waitDone();
    applyStimulus(F3_REMU, 32'd5, 32'd0, 1, 32'd5, "REMU 5/0", 0);
    waitDone();
    applyStimulus(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "DIV overflow", 0);
    waitDone();
    applyStimulus(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "REM overflow", 0);
    waitDone();
    applyStimulus(F3_DIVU, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, "DIVU 9/0", 0);
    waitDone();
    applyStimulus(F3_REM, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, "REM -7/0", 0);
    waitDone();
    applyStimulus(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "DIVU min/max", 0);
    waitDone();
    tick(); tick();

    // Kill ten cycles into a divide, with a competing start in the same cycle.
    applyStimulus(F3_DIVU, 32'd1000, 32'd3, 0, '0, "DIVU killed", 0);
    repeat (9) tick();
    applyStimulus(F3_MUL, 32'd2, 32'd2, 0, '0, "MUL under kill", 1);
    repeat (40) tick();

    // Asynchronous reset between edges in the middle of a multiply.
    applyStimulus(F3_MUL, 32'h0000_1234, 32'h0000_5678, 0, '0, "MUL reset", 0);
    repeat (5) tick();
    pulseReset();
    tick();
    applyStimulus(F3_MUL, 32'd3, 32'd4, 1, 32'd12, "MUL 3*4", 0);
    waitDone();
    repeat (3) tick();

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
